silu_glu_gate: RTL

//  Downstream consumer of the SiLU PWL stage in the FFN activation path.

---
 rtl/ffn_fx_pkg.sv | 42 ++++
 rtl/glu_out_fifo.sv | 61 ++++++
 rtl/silu_glu_gate.sv | 80 ++++++++
 3 files changed

// File: rtl/ffn_fx_pkg.sv
// Fixed-point constants and the round/saturate helper for the FFN activation path.
// All operands and results are signed Q6.9.
package ffn_fx_pkg;

    localparam int DW   = 16;
    localparam int FRAC = 9;
    localparam int PW   = 2 * DW;

    localparam logic [DW-1:0] Q_ONE   = 16'h0200;
    localparam logic [DW-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DW-1:0] SAT_MIN = 16'h8000;

    typedef struct packed {
        logic          sat;
        logic [DW-1:0] data;
    } glu_beat_t;

    // Q12.18 product -> Q6.9: add half an LSB, shift arithmetically, clip to DW bits.
    function automatic glu_beat_t sat_round_q69(input logic signed [PW-1:0] prod);
        logic signed [PW:0] biased;
        logic signed [PW:0] shifted;
        logic signed [PW:0] hi;
        logic signed [PW:0] lo;
        glu_beat_t          beat;
        hi      = (PW+1)'($signed(SAT_MAX));
        lo      = (PW+1)'($signed(SAT_MIN));
        biased  = (PW+1)'(prod) + (PW+1)'(1 << (FRAC - 1));
        shifted = biased >>> FRAC;
        if (shifted > hi) begin
            beat.sat  = 1'b1;
            beat.data = SAT_MAX;
        end else if (shifted < lo) begin
            beat.sat  = 1'b1;
            beat.data = SAT_MIN;
        end else begin
            beat.sat  = 1'b0;
            beat.data = shifted[DW-1:0];
        end
        return beat;
    endfunction

endpackage

// File: rtl/glu_out_fifo.sv
// Synchronous output FIFO for gated results; head is shown combinationally,
// and reads as zero while empty.
module glu_out_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme must make this impossible.
    overflow_check: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/silu_glu_gate.sv
// SwiGLU gate: drives the SiLU unit, multiplies its result by the aligned up operand,
// rounds/saturates to Q6.9 and buffers behind a credit-protected output FIFO.
module silu_glu_gate
    import ffn_fx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_gate,
    input  logic [DW-1:0] s_up,
    output logic [DW-1:0] silu_x,
    input  logic [DW-1:0] silu_y,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_sat
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(DEPTH + 3);

    logic                 fire;
    logic                 p1_vld;
    logic                 p2_vld;
    logic [DW-1:0]        p1_up;
    logic signed [PW-1:0] p2_prod;
    logic [CW-1:0]        fifo_count;
    logic [OW-1:0]        occ;
    logic                 fifo_empty;
    glu_beat_t            push_beat;
    glu_beat_t            head_beat;

    // Every beat in flight or buffered holds a credit until it leaves the FIFO,
    // so P1/P2 can run freely without ever overrunning it.
    assign silu_x  = s_gate;
    assign occ     = OW'(p1_vld) + OW'(p2_vld) + OW'(fifo_count);
    assign s_ready = rst_n && (occ < OW'(DEPTH));
    assign fire    = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_vld  <= 1'b0;
            p1_up   <= '0;
            p2_vld  <= 1'b0;
            p2_prod <= '0;
        end else begin
            p1_vld <= fire;
            p2_vld <= p1_vld;
            if (fire) begin
                p1_up <= s_up;
            end
            if (p1_vld) begin
                p2_prod <= PW'($signed(silu_y)) * PW'($signed(p1_up));
            end
        end
    end

    assign push_beat = sat_round_q69(p2_prod);

    glu_out_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(glu_beat_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (p2_vld),
        .push_data (push_beat),
        .pop       (m_ready),
        .pop_data  (head_beat),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = head_beat.data;
    assign m_sat   = head_beat.sat;

endmodule
